bht_satctr: RTL and testbench

- Parametrised branch history table for the frontend. Successor to the 1-bit valid-only table.
- Holds an N-bit saturating direction counter plus a valid bit per entry. Entries are organised as NR_ENTRIES/INSTR_PER_FETCH rows of INSTR_PER_FETCH lanes.
- Gives one prediction per fetch lane every cycle. Trains from resolved branches coming out of the backend.

---
 rtl/bht_satctr.sv | 145 ++++++++++++++
 tb/tb_bht_satctr.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_satctr.sv
// bht_satctr: branch history table of saturating direction counters.
// Ports:
//   clk_i, rst_ni  : clock, async active-low reset
//   flush_i        : invalidate whole table (wins over a same-cycle update)
//   debug_mode_i   : block training
//   vpc_i          : fetch block PC -> pred_valid_o / pred_taken_o per lane
//   update_*       : resolved branch training port
// Optional macro BHT_GSHARE_EN: XOR a global history register into the row index.
module bht_satctr #(
    parameter int unsigned NR_ENTRIES      = 1024,
    parameter int unsigned INSTR_PER_FETCH = 2,
    parameter int unsigned CTR_BITS        = 2,
    parameter int unsigned VLEN            = 39,
    parameter int unsigned GHR_BITS        = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       debug_mode_i,
    input  logic [VLEN-1:0]            vpc_i,
    input  logic                       update_valid_i,
    input  logic [VLEN-1:0]            update_pc_i,
    input  logic                       update_taken_i,
    output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
    output logic [INSTR_PER_FETCH-1:0] pred_taken_o
);
    localparam int unsigned NR_ROWS   = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int unsigned RB        = $clog2(INSTR_PER_FETCH);
    localparam int unsigned ROW_BITS  = $clog2(NR_ROWS);
    localparam int unsigned LANE_BITS = (RB > 0) ? RB : 1;

    localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    if (INSTR_PER_FETCH == 0 ||
        (INSTR_PER_FETCH & (INSTR_PER_FETCH - 1)) != 0) begin : g_err_ipf
        $error("INSTR_PER_FETCH must be a power of two");
    end
    if (NR_ENTRIES == 0 || (NR_ENTRIES & (NR_ENTRIES - 1)) != 0 ||
        (NR_ENTRIES % INSTR_PER_FETCH) != 0) begin : g_err_entries
        $error("NR_ENTRIES must be a power of two and a multiple of INSTR_PER_FETCH");
    end
    if (NR_ROWS < 2) begin : g_err_rows
        $error("table needs at least two rows");
    end
    if (CTR_BITS < 1 || CTR_BITS > 4) begin : g_err_ctr
        $error("CTR_BITS must be 1..4");
    end
    if (GHR_BITS < 1 || GHR_BITS > ROW_BITS) begin : g_err_ghr
        $error("GHR_BITS must be 1..clog2(NR_ROWS)");
    end

    logic [NR_ROWS-1:0][INSTR_PER_FETCH-1:0]               valid_q;
    logic [NR_ROWS-1:0][INSTR_PER_FETCH-1:0][CTR_BITS-1:0] ctr_q;

    logic [ROW_BITS-1:0]  row_hist;
    logic [ROW_BITS-1:0]  rd_row;
    logic [ROW_BITS-1:0]  wr_row;
    logic [LANE_BITS-1:0] wr_lane;
    logic                 upd_acc;
    logic                 cur_vld;
    logic [CTR_BITS-1:0]  cur_ctr;
    logic [CTR_BITS-1:0]  nxt_ctr;
    logic                 unused_pc;

    // Only the row and lane bits of either PC take part in indexing.
    assign unused_pc = ^{vpc_i, update_pc_i};

    assign upd_acc = update_valid_i & ~debug_mode_i & ~flush_i;

`ifdef BHT_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ghr_q <= '0;
        end else if (flush_i) begin
            ghr_q <= '0;
        end else if (upd_acc) begin
            // Shift in the newest outcome, oldest history bit falls off.
            ghr_q <= GHR_BITS'({ghr_q, update_taken_i});
        end
    end

    assign row_hist = ROW_BITS'(ghr_q);
`else
    assign row_hist = '0;
`endif

    // Training indexes with the pre-shift history, same as prediction.
    assign rd_row = vpc_i[RB+1 +: ROW_BITS] ^ row_hist;
    assign wr_row = update_pc_i[RB+1 +: ROW_BITS] ^ row_hist;

    if (RB > 0) begin : g_lane
        assign wr_lane = update_pc_i[1 +: LANE_BITS];
    end else begin : g_lane_one
        assign wr_lane = '0;
    end

    always_comb begin
        pred_valid_o = '0;
        pred_taken_o = '0;
        for (int i = 0; i < INSTR_PER_FETCH; i++) begin
            pred_valid_o[i] = valid_q[rd_row][i];
            pred_taken_o[i] = valid_q[rd_row][i] &
                              ctr_q[rd_row][i][CTR_BITS-1];
        end
    end

    assign cur_vld = valid_q[wr_row][wr_lane];
    assign cur_ctr = ctr_q[wr_row][wr_lane];

    // A fresh entry starts weak in the observed direction; a live one
    // saturates at both ends.
    always_comb begin
        nxt_ctr = cur_ctr;
        unique case (1'b1)
            !cur_vld: begin
                nxt_ctr = update_taken_i ? CTR_WT : CTR_WNT;
            end
            cur_vld && update_taken_i: begin
                nxt_ctr = (cur_ctr == CTR_MAX) ? cur_ctr : cur_ctr + 1'b1;
            end
            cur_vld && !update_taken_i: begin
                nxt_ctr = (cur_ctr == '0) ? cur_ctr : cur_ctr - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            ctr_q   <= {NR_ENTRIES{CTR_WNT}};
        end else if (flush_i) begin
            valid_q <= '0;
            ctr_q   <= {NR_ENTRIES{CTR_WNT}};
        end else if (upd_acc) begin
            valid_q[wr_row][wr_lane] <= 1'b1;
            ctr_q[wr_row][wr_lane]   <= nxt_ctr;
        end
    end

endmodule

// File: tb/tb_bht_satctr.sv
// tb_bht_satctr: directed + table-driven check of bht_satctr against
// an arithmetic model of the counter table.
module tb_bht_satctr;
    localparam int NR_ENTRIES = 1024;
    localparam int IPF        = 2;
    localparam int CTR_BITS   = 2;
    localparam int VLEN       = 39;
    localparam int GHR_BITS   = 8;
    localparam int ROWS       = NR_ENTRIES / IPF;
    localparam int HALF       = 1 << (CTR_BITS - 1);
    localparam int CMAX       = (1 << CTR_BITS) - 1;

    logic            clk_i          = 1'b0;
    logic            rst_ni         = 1'b0;
    logic            flush_i        = 1'b0;
    logic            debug_mode_i   = 1'b0;
    logic [VLEN-1:0] vpc_i          = '0;
    logic            update_valid_i = 1'b0;
    logic [VLEN-1:0] update_pc_i    = '0;
    logic            update_taken_i = 1'b0;
    logic [IPF-1:0]  pred_valid_o;
    logic [IPF-1:0]  pred_taken_o;

    int mvalid[NR_ENTRIES];
    int mctr[NR_ENTRIES];
    int mghr   = 0;
    int errors = 0;
    int checks = 0;

    bht_satctr #(
        .NR_ENTRIES     (NR_ENTRIES),
        .INSTR_PER_FETCH(IPF),
        .CTR_BITS       (CTR_BITS),
        .VLEN           (VLEN),
        .GHR_BITS       (GHR_BITS)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .debug_mode_i  (debug_mode_i),
        .vpc_i         (vpc_i),
        .update_valid_i(update_valid_i),
        .update_pc_i   (update_pc_i),
        .update_taken_i(update_taken_i),
        .pred_valid_o  (pred_valid_o),
        .pred_taken_o  (pred_taken_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int row_of(logic [VLEN-1:0] pc);
        return int'((pc / (2 * IPF)) % ROWS) ^ mghr;
    endfunction

    function automatic int lane_of(logic [VLEN-1:0] pc);
        return int'((pc / 2) % IPF);
    endfunction

    task automatic model_reset();
        for (int e = 0; e < NR_ENTRIES; e++) begin
            mvalid[e] = 0;
            mctr[e]   = HALF - 1;
        end
        mghr = 0;
    endtask

    task automatic model_update();
        int e;
        if (flush_i) begin
            model_reset();
        end else if (update_valid_i && !debug_mode_i) begin
            e = row_of(update_pc_i) * IPF + lane_of(update_pc_i);
            if (mvalid[e] == 0) begin
                mvalid[e] = 1;
                mctr[e]   = update_taken_i ? HALF : HALF - 1;
            end else if (update_taken_i) begin
                mctr[e] = (mctr[e] + 1 > CMAX) ? CMAX : mctr[e] + 1;
            end else begin
                mctr[e] = (mctr[e] - 1 < 0) ? 0 : mctr[e] - 1;
            end
`ifdef BHT_GSHARE_EN
            mghr = ((mghr * 2) + (update_taken_i ? 1 : 0)) % (1 << GHR_BITS);
`endif
        end
    endtask

    // Model comparison on every cycle.
    initial begin
        logic [IPF-1:0] ev;
        logic [IPF-1:0] et;
        int r;
        forever begin
            @(negedge clk_i);
            r = row_of(vpc_i);
            for (int i = 0; i < IPF; i++) begin
                ev[i] = (mvalid[r * IPF + i] != 0);
                et[i] = ev[i] && (mctr[r * IPF + i] >= HALF);
            end
            checks++;
            if (pred_valid_o !== ev || pred_taken_o !== et) begin
                errors++;
                $display("FAIL pred vpc=%h got v=%b t=%b exp v=%b t=%b",
                         vpc_i, pred_valid_o, pred_taken_o, ev, et);
            end
        end
    end

    // Hand-computed expectations assume the plain PC index.
    task automatic lit(string name, logic [IPF-1:0] act, logic [IPF-1:0] exp);
`ifndef BHT_GSHARE_EN
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, act, exp);
        end
`endif
    endtask

    task automatic cyc(logic uv, logic [VLEN-1:0] upc, logic tk,
                       logic [VLEN-1:0] vpc, logic fl, logic dbg);
        update_valid_i = uv;
        update_pc_i    = upc;
        update_taken_i = tk;
        vpc_i          = vpc;
        flush_i        = fl;
        debug_mode_i   = dbg;
        @(negedge clk_i);
    endtask

    task automatic step();
        @(posedge clk_i);
        if (rst_ni) model_update();
        #1;
    endtask

    logic [5:0]      seq3 = 6'b110001;
    logic [5:0]      exp3 = 6'b100001;
    logic [4:0]      seq4 = 5'b00111;
    logic [4:0]      exp4 = 5'b01111;
    logic [VLEN-1:0] pcs[6];

    initial begin
        model_reset();
        pcs[0] = 39'h1004; pcs[1] = 39'h1006; pcs[2] = 39'h1804;
        pcs[3] = 39'h2000; pcs[4] = 39'h2002; pcs[5] = 39'h3ffe;

        // Reset state
        cyc(0, '0, 0, 39'h1004, 0, 0);
        lit("rst_valid", pred_valid_o, 2'b00);
        lit("rst_taken", pred_taken_o, 2'b00);
        vpc_i = 39'h3ffe;
        #1 lit("rst_valid_any", pred_valid_o, 2'b00);
        step();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // First training, same-cycle read sees old value
        cyc(1, 39'h1004, 1, 39'h1004, 0, 0);
        lit("same_cycle_valid", pred_valid_o, 2'b00);
        step();
        cyc(0, '0, 0, 39'h1004, 0, 0);
        lit("train_valid", pred_valid_o, 2'b01);
        lit("train_taken", pred_taken_o, 2'b01);
        step();

        // Hysteresis and bottom saturation on lane 1
        for (int k = 0; k < 6; k++) begin
            cyc(1, 39'h1006, seq3[k], 39'h1004, 0, 0);
            step();
            cyc(0, '0, 0, 39'h1004, 0, 0);
            lit($sformatf("hyst_%0d", k), {1'b0, pred_taken_o[1]}, {1'b0, exp3[k]});
            step();
        end
        cyc(0, '0, 0, 39'h1004, 0, 0);
        lit("both_valid", pred_valid_o, 2'b11);
        step();

        // Top saturation: 2 -> 3,3,3,2,1
        for (int k = 0; k < 5; k++) begin
            cyc(1, 39'h1006, seq4[k], 39'h1004, 0, 0);
            step();
            cyc(0, '0, 0, 39'h1004, 0, 0);
            lit($sformatf("sat_%0d", k), {1'b0, pred_taken_o[1]}, {1'b0, exp4[k]});
            step();
        end

        // Flush beats a same-cycle update
        cyc(1, 39'h1006, 1, 39'h1004, 1, 0);
        step();
        cyc(0, '0, 0, 39'h1004, 0, 0);
        lit("flush_valid", pred_valid_o, 2'b00);
        step();
        cyc(0, '0, 0, 39'h1004, 0, 0);
        lit("flush_drop", pred_valid_o, 2'b00);
        step();

        // Debug mode blocks training only
        cyc(1, 39'h2000, 1, 39'h2000, 0, 1);
        step();
        cyc(0, '0, 0, 39'h2000, 0, 1);
        lit("dbg_blocked", pred_valid_o, 2'b00);
        step();
        cyc(1, 39'h2000, 1, 39'h2000, 0, 0);
        step();
        cyc(0, '0, 0, 39'h2000, 0, 1);
        lit("dbg_predicts", pred_valid_o, 2'b01);
        step();

        // Aliasing: 0x1804 shares row 1 with 0x1004
        cyc(1, 39'h1004, 1, 39'h1804, 0, 0);
        step();
        cyc(0, '0, 0, 39'h1804, 0, 0);
        lit("alias_taken", {1'b0, pred_taken_o[0]}, 2'b01);
        step();

        // Asynchronous reset in the middle of an update
        cyc(1, 39'h1004, 0, 39'h1004, 0, 0);
        #2 rst_ni = 1'b0;
        #1 lit("async_rst_valid", pred_valid_o, 2'b00);
        model_reset();
        step();
        rst_ni = 1'b1;
        cyc(0, '0, 0, 39'h1004, 0, 0);
        lit("rst_drops_update", pred_valid_o, 2'b00);
        step();

        // Weak not-taken on a fresh entry
        cyc(1, 39'h1004, 0, 39'h1004, 0, 0);
        step();
        cyc(0, '0, 0, 39'h1004, 0, 0);
        lit("wnt_valid", pred_valid_o, 2'b01);
        lit("wnt_taken", pred_taken_o, 2'b00);
        step();

        // Mixed traffic checked by the model
        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(0, 3) != 0,
                pcs[$urandom_range(0, 5)],
                $urandom_range(0, 1) == 1,
                pcs[$urandom_range(0, 5)],
                $urandom_range(0, 39) == 0,
                $urandom_range(0, 7) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
